// File: rtl/jtframe_sndavg_gain_if.sv
// Sample bus between the PSG filter chain, the decimating averager and the mixer.
// The master drives input samples and gain; the slave returns averaged output samples.
interface jtframe_sndavg_gain_if #(
    parameter int GW = 8
);
    logic signed [15:0] din;
    logic               sample;
    logic [GW-1:0]      gain;
    logic signed [15:0] dout;
    logic               sample_out;
    logic               sat;

    modport master (output din, sample, gain, input dout, sample_out, sat);
    modport slave  (input din, sample, gain, output dout, sample_out, sat);
endinterface

// File: rtl/jtframe_sndavg_gain.sv
// Decimating averager for 16-bit PSG audio: averages 2^DECIM samples, applies a 4.4
// gain and saturates to 16 bits. Three-stage pipeline: accumulate, multiply, clamp.
module jtframe_sndavg_gain #(
    parameter int DECIM = 2,
    parameter int GW    = 8
) (
    input logic                  clk,
    input logic                  rst,
    jtframe_sndavg_gain_if.slave bus
);
    localparam int CW = (DECIM > 0) ? DECIM : 1;
    localparam int AW = 16 + DECIM;
    localparam int PW = 16 + GW + 1;
    // With DECIM=0 the counter stays at zero, so every sample closes a group.
    localparam logic [CW-1:0]        CNT_LAST = CW'((1 << DECIM) - 1);
    localparam logic signed [PW-1:0] MAX_V    = PW'(32767);
    localparam logic signed [PW-1:0] MIN_V    = PW'(-32768);

    logic [CW-1:0]        cnt_q, cnt_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic signed [15:0]   avg_q, avg_d;
    logic signed [PW-1:0] prod_q, prod_d;
    logic                 v1_q, v1_d;
    logic                 v2_q, v2_d;
    logic signed [15:0]   dout_q, dout_d;
    logic                 sat_q, sat_d;
    logic                 so_q, so_d;

    logic signed [AW-1:0] sum;
    logic signed [PW-1:0] t;

    always_comb begin
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        avg_d  = avg_q;
        v1_d   = 1'b0;
        sum    = acc_q + AW'(bus.din);
        if (bus.sample) begin
            if (cnt_q != CNT_LAST) begin
                acc_d = sum;
                cnt_d = CW'(cnt_q + 1'b1);
            end else begin
                avg_d = 16'(sum >>> DECIM);
                acc_d = '0;
                cnt_d = '0;
                v1_d  = 1'b1;
            end
        end

        prod_d = PW'(avg_q) * PW'($signed({1'b0, bus.gain}));
        v2_d   = v1_q;

        t      = prod_q >>> 4;
        dout_d = dout_q;
        sat_d  = sat_q;
        so_d   = v2_q;
        if (v2_q) begin
            if (t > MAX_V) begin
                dout_d = 16'sh7fff;
                sat_d  = 1'b1;
            end else if (t < MIN_V) begin
                dout_d = -16'sh8000;
                sat_d  = 1'b1;
            end else begin
                dout_d = t[15:0];
                sat_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            avg_q  <= '0;
            prod_q <= '0;
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            dout_q <= '0;
            sat_q  <= 1'b0;
            so_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            avg_q  <= avg_d;
            prod_q <= prod_d;
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            dout_q <= dout_d;
            sat_q  <= sat_d;
            so_q   <= so_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.sat        = sat_q;
    assign bus.sample_out = so_q;

endmodule

// File: tb/tb_jtframe_sndavg_gain.sv
// Bench for jtframe_sndavg_gain: a DECIM=2 and a DECIM=0 instance, each with a
// scoreboard of expected output samples and their due cycle.
module tb_jtframe_sndavg_gain;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    typedef struct {
        int dout;
        int sat;
        int due;
    } exp_t;

    exp_t q2[$];
    exp_t q0[$];
    int   m_acc = 0;
    int   m_cnt = 0;

    jtframe_sndavg_gain_if #(.GW(8)) if2 ();
    jtframe_sndavg_gain_if #(.GW(8)) if0 ();

    jtframe_sndavg_gain #(.DECIM(2), .GW(8)) u_d2 (.clk(clk), .rst(rst), .bus(if2));
    jtframe_sndavg_gain #(.DECIM(0), .GW(8)) u_d0 (.clk(clk), .rst(rst), .bus(if0));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t make_exp(input int avg, input int g, input int due);
        exp_t e;
        int t;
        t = (avg * g) >>> 4;
        e.due = due;
        if (t > 32767) begin
            e.dout = 32767;  e.sat = 1;
        end else if (t < -32768) begin
            e.dout = -32768; e.sat = 1;
        end else begin
            e.dout = t;      e.sat = 0;
        end
        return e;
    endfunction

    // gap = extra idle cycles after the strobe; strobe spacing is gap + 2
    task automatic send2(input int d, input int gap);
        @(negedge clk);
        if2.sample = 1'b1;
        if2.din    = 16'(d);
        m_acc += d;
        m_cnt++;
        if (m_cnt == 4) begin
            q2.push_back(make_exp(m_acc >>> 2, int'(if2.gain), cyc + 3));
            m_acc = 0;
            m_cnt = 0;
        end
        @(negedge clk);
        if2.sample = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic group2(input int d0, input int d1, input int d2, input int d3);
        send2(d0, 0); send2(d1, 0); send2(d2, 0); send2(d3, 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q2.size() != 0 || q0.size() != 0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("drain_timeout", q2.size() + q0.size(), 0);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (if2.sample_out) begin
                if (q2.size() == 0) chk("d2_spurious_pulse", 1, 0);
                else begin
                    e = q2.pop_front();
                    chk("d2_dout", if2.dout, e.dout);
                    chk("d2_sat", if2.sat, e.sat);
                    chk("d2_latency", cyc, e.due);
                end
            end
            if (if0.sample_out) begin
                if (q0.size() == 0) chk("d0_spurious_pulse", 1, 0);
                else begin
                    e = q0.pop_front();
                    chk("d0_dout", if0.dout, e.dout);
                    chk("d0_sat", if0.sat, e.sat);
                    chk("d0_latency", cyc, e.due);
                end
            end
        end
    end

    initial begin
        if2.sample = 1'b0; if2.din = '0; if2.gain = 8'h10;
        if0.sample = 1'b0; if0.din = '0; if0.gain = 8'h10;
        repeat (3) @(negedge clk);
        chk("rst_dout", if2.dout, 0);
        chk("rst_sample_out", if2.sample_out, 0);
        chk("rst_sat", if2.sat, 0);
        chk("rst_d0_dout", if0.dout, 0);
        rst = 1'b0;

        // averaging with spaced strobes
        send2(100, 3); send2(200, 3); send2(300, 3); send2(400, 3);
        drain();
        chk("t1_dout", if2.dout, 250);
        chk("t1_sat", if2.sat, 0);

        // floor rounding
        group2(-1, 0, 0, 0);
        drain();
        chk("t2_neg_floor", if2.dout, -1);
        group2(1, 0, 0, 0);
        drain();
        chk("t2_pos_floor", if2.dout, 0);

        // saturation
        if2.gain = 8'h20;
        group2(20000, 20000, 20000, 20000);
        drain();
        chk("t3_pos_sat_dout", if2.dout, 32767);
        chk("t3_pos_sat", if2.sat, 1);
        group2(-20000, -20000, -20000, -20000);
        drain();
        chk("t3_neg_sat_dout", if2.dout, -32768);
        chk("t3_neg_sat", if2.sat, 1);
        group2(1000, 1000, 1000, 1000);
        drain();
        chk("t3_nosat_dout", if2.dout, 2000);
        chk("t3_nosat", if2.sat, 0);

        // fractional gain and zero gain
        if2.gain = 8'h08;
        group2(1001, 1001, 1001, 1001);
        drain();
        chk("t4_half_gain", if2.dout, 500);
        if2.gain = 8'h00;
        group2(1001, 1001, 1001, 1001);
        drain();
        chk("t4_zero_gain", if2.dout, 0);

        // partial group dropped by reset
        if2.gain = 8'h10;
        send2(7000, 0); send2(7000, 0);
        @(negedge clk);
        rst = 1'b1;
        m_acc = 0;
        m_cnt = 0;
        @(negedge clk);
        chk("t5_rst_dout", if2.dout, 0);
        chk("t5_rst_sample_out", if2.sample_out, 0);
        chk("t5_rst_sat", if2.sat, 0);
        rst = 1'b0;
        group2(4, 4, 4, 4);
        drain();
        chk("t5_new_group", if2.dout, 4);

        // DECIM=0 back-to-back pass-through
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if0.sample = 1'b1;
            if0.din    = 16'(i);
            q0.push_back(make_exp(i, int'(if0.gain), cyc + 3));
        end
        @(negedge clk);
        if0.sample = 1'b0;
        drain();
        chk("t6_last_dout", if0.dout, 7);

        chk("q2_empty", q2.size(), 0);
        chk("q0_empty", q0.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/jtframe_sndavg_gain.md
# jtframe_sndavg_gain

Decimating averager with gain and saturation for 16-bit signed PSG audio. It sits directly after the PSG filter chain and consumes its 16-bit signed output at the filter sample strobe. Each group of 2^DECIM consecutive samples is averaged, scaled by a 4.4 fixed-point gain and clamped to 16 bits. The result is presented with a one-cycle output strobe to the sound mixer.

## Interface

**Parameters**
- `DECIM`, default 2: log2 of the decimation factor, legal range 0..4. With 0, every sample passes through.
- `GW`, default 8: gain width. Unsigned fixed point with 4 fractional bits, so 0x10 is unity.

**Ports**
- `clk`, in, 1: system clock. One clock domain only.
- `rst`, in, 1: reset, synchronous and active-high.
- `din`, in, 16: signed input sample.
- `sample`, in, 1: input strobe. `din` is valid in any cycle where this is high; one accepted sample per cycle max.
- `gain`, in, GW: unsigned gain, sampled at the multiply stage.
- `dout`, out, 16: signed output sample. Holds its value between strobes.
- `sample_out`, out, 1: one-cycle pulse when `dout` is updated.
- `sat`, out, 1: flag that `dout` was clamped. Updated together with `dout`.

## Operation

**Accumulate stage**
- Registers:
  - counter `cnt`, DECIM bits;
  - accumulator `acc`, signed 16+DECIM bits.
- When `sample`=1 and `cnt` != 2^DECIM−1: `acc <= acc + din`, `cnt <= cnt + 1`.
- When `sample`=1 and `cnt` == 2^DECIM−1 (always true for DECIM=0):
  - `avg <= (acc + din) >>> DECIM`, an arithmetic shift with floor rounding;
  - `acc <= 0`, `cnt <= 0`, `v1 <= 1`.
- Otherwise `v1 <= 0`.

**Multiply stage**
- `prod <= avg * $signed({1'b0, gain})`.
- Width is 16+GW+1 signed, so no overflow is possible.
- `v2 <= v1`.

**Output stage**
- When `v2`=1:
  - `t = prod >>> 4` (floor);
  - if t > 32767: `dout <= 32767`, `sat <= 1`;
  - if t < −32768: `dout <= −32768`, `sat <= 1`;
  - otherwise `dout <= t[15:0]`, `sat <= 0`;
  - `sample_out <= 1`.
- When `v2`=0: `sample_out <= 0`. `dout` and `sat` hold.

**General rules**
- The pipeline is fully pipelined with no stall and no backpressure. The downstream block must accept a `sample_out` pulse in any cycle.
- `gain` changes take effect on the next multiply-stage cycle. There is no glitch protection; the average is not re-used.

**Reset (synchronous)**
- `acc`, `cnt`, `avg`, `prod`, `v1` and `v2` are cleared.
- Output values: `dout`=0, `sample_out`=0, `sat`=0.
- A partially filled group at reset is discarded. Items in the pipeline are dropped and produce no strobe.

## Timing

- Latency: if the last sample of a group has `sample`=1 in cycle n, then `sample_out`=1 in cycle n+3, with the new `dout`/`sat` valid in that same cycle.
- Throughput: one output per 2^DECIM accepted samples. With DECIM=0 and `sample` high every cycle, `sample_out` is high every cycle after a 3-cycle fill.
- Gaps between `sample` strobes do not affect grouping. The counter advances only on strobes.
- `rst` wins over `sample` in the same cycle: that sample is discarded.
- `sample` in the cycle right after `rst` deasserts is accepted as the first sample of a group.

## Test plan

1. DECIM=2, `gain`=0x10, `din` = 100, 200, 300, 400 on strobes spaced 5 cycles apart.
   - Expect `dout`=250 and `sat`=0.
   - Expect exactly one `sample_out` pulse, 3 cycles after the 4th strobe.
2. DECIM=2, `gain`=0x10, `din` = −1, 0, 0, 0.
   - Expect `dout`=−1 (floor of −0.25).
   - Then `din` = 1, 0, 0, 0: expect `dout`=0.
3. DECIM=2, `gain`=0x20, four samples of 20000.
   - Expect `dout`=32767, `sat`=1.
   - Then four samples of −20000: expect `dout`=−32768, `sat`=1.
   - Then four samples of 1000: expect `dout`=2000, `sat`=0.
4. DECIM=2, `gain`=0x08, four samples of 1001.
   - Expect `dout`=500, since 8008>>4 floors 500.5.
   - Then `gain`=0x00: expect `dout`=0.
5. DECIM=2: two samples of 7000, then one cycle of `rst`, then four samples of 4.
   - Expect no `sample_out` pulse before the new group completes.
   - Expect `dout`=4 from the new group.
   - During `rst` the outputs read `dout`=0, `sample_out`=0, `sat`=0.
6. DECIM=0, `gain`=0x10, `sample` high on 8 consecutive cycles with `din` = 0..7.
   - Expect 8 consecutive `sample_out` pulses starting 3 cycles after the first strobe.
   - Expect `dout` = 0..7 in order.
